nv_ram_rws_param: RTL and testbench

- Parametrised successor to the fixed-size two-port RAM models (one read port, one write port, single clock, synchronous read).
- Adds configurable width/depth, a post-reset clear sweep, selectable read-during-write behaviour, an optional output pipeline stage and a read-valid strobe.
- Used as the FPGA RAM model behind NVDLA FIFOs and line buffers wherever a non-standard size is needed.

---
 rtl/nv_ram_rws_param.sv | 173 +++++++++++++++++
 tb/tb_nv_ram_rws_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rws_param.sv
// Parametrised one-read/one-write synchronous RAM. It has a post-reset zero sweep,
// selectable read-during-write forwarding and an optional second output stage.
module nv_ram_rws_param #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int AW         = 5,
    parameter int BYPASS     = 1,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    output logic             init_busy,
    input  logic [31:0]      pwrbus_ram_pd
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    sweep_q, sweep_d;
    logic             init_busy_q, init_busy_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             s1_vld_q, s1_vld_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             mem_we_s;
    logic [IW-1:0]    mem_wa_s;
    logic [WIDTH-1:0] mem_wd_s;
    logic             rd_acc_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             wa_ok_s;
    logic             ra_ok_s;
    logic             unused_ok_s;

    assign unused_ok_s = ^pwrbus_ram_pd;

    // Sweep/ready control, write-port steering and read-data selection.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        init_busy_d = init_busy_q;
        mem_we_s    = 1'b0;
        mem_wa_s    = '0;
        mem_wd_s    = '0;
        rd_acc_s    = 1'b0;
        rd_data_s   = '0;
        wa_ok_s     = (32'(wa) < 32'(DEPTH));
        ra_ok_s     = (32'(ra) < 32'(DEPTH));
        case (state_q)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                mem_wa_s = sweep_q;
                mem_wd_s = '0;
                if ((INIT_CLEAR == 0) || (sweep_q == IW'(DEPTH - 1))) begin
                    state_d     = ST_READY;
                    sweep_d     = '0;
                    init_busy_d = 1'b0;
                end else begin
                    sweep_d     = sweep_q + IW'(1);
                    init_busy_d = 1'b1;
                end
            end
            ST_READY: begin
                init_busy_d = 1'b0;
                if (we && wa_ok_s) begin
                    mem_we_s = 1'b1;
                    mem_wa_s = wa[IW-1:0];
                    mem_wd_s = di;
                end else begin
                    mem_we_s = 1'b0;
                end
                if (re) begin
                    rd_acc_s = 1'b1;
                    // The same-cycle write is only visible to the read when forwarding.
                    if (!ra_ok_s) begin
                        rd_data_s = '0;
                    end else if ((BYPASS != 0) && we && (wa == ra)) begin
                        rd_data_s = di;
                    end else begin
                        rd_data_s = mem[ra[IW-1:0]];
                    end
                end else begin
                    rd_acc_s = 1'b0;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                sweep_d     = '0;
                init_busy_d = 1'b1;
            end
        endcase
        s1_vld_d  = rd_acc_s;
        if (rd_acc_s) begin
            s1_data_d = rd_data_s;
        end else begin
            s1_data_d = s1_data_q;
        end
    end

    // Storage array; contents are deliberately untouched by rst.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[mem_wa_s] <= mem_wd_s;
        end
    end

    // Control state and first read stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
            sweep_q     <= '0;
            init_busy_q <= (INIT_CLEAR != 0);
            s1_data_q   <= '0;
            s1_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_busy_q <= init_busy_d;
            s1_data_q   <= s1_data_d;
            s1_vld_q    <= s1_vld_d;
        end
    end

    assign init_busy = init_busy_q;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [WIDTH-1:0] o_data_q, o_data_d;
            logic             o_vld_q, o_vld_d;

            // Second stage only captures a completed read, so dout holds otherwise.
            always_comb begin
                o_vld_d = s1_vld_q;
                if (s1_vld_q) begin
                    o_data_d = s1_data_q;
                end else begin
                    o_data_d = o_data_q;
                end
            end

            // Output stage registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_data_q <= '0;
                    o_vld_q  <= 1'b0;
                end else begin
                    o_data_q <= o_data_d;
                    o_vld_q  <= o_vld_d;
                end
            end

            assign dout     = o_data_q;
            assign dout_vld = o_vld_q;
        end else begin : g_no_out_reg
            assign dout     = s1_data_q;
            assign dout_vld = s1_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_nv_ram_rws_param.sv
// Scoreboard bench: two RAM configurations share the same stimulus, and each has its own
// behavioural memory model and expected-response queue.
module tb_nv_ram_rws_param;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ra = 5'd0;
    logic        re = 1'b0;
    logic [4:0]  wa = 5'd0;
    logic        we = 1'b0;
    logic [31:0] di = 32'h0;
    logic [31:0] pwr = 32'h0;

    logic [31:0] dout_a, dout_b;
    logic        vld_a, vld_b, busy_a, busy_b;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        rst_s = 1'b0;
    logic        model_on = 1'b0;

    exp_t        sb [2][$];
    logic [31:0] mdl [2][32];
    logic [31:0] last [2];
    int          depth_k [2] = '{32, 24};
    int          bypass_k [2] = '{1, 0};
    int          lat_k [2] = '{1, 2};
    string       nm [2] = '{"a", "b"};

    // Config A: full-size, forwarding, latency 1.
    nv_ram_rws_param #(.WIDTH(32), .DEPTH(32), .AW(5), .BYPASS(1), .OUT_REG(0), .INIT_CLEAR(1)) u_a (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
        .wa(wa), .we(we), .di(di), .init_busy(busy_a), .pwrbus_ram_pd(pwr)
    );

    // Config B: non-power-of-two depth, read-old-data, latency 2.
    nv_ram_rws_param #(.WIDTH(32), .DEPTH(24), .AW(5), .BYPASS(0), .OUT_REG(1), .INIT_CLEAR(1)) u_b (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
        .wa(wa), .we(we), .di(di), .init_busy(busy_b), .pwrbus_ram_pd(pwr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= rst;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of port activity and update the reference model.
    task automatic step(input logic r_e, input logic [4:0] r_a, input logic w_e,
                        input logic [4:0] w_a, input logic [31:0] w_d);
        @(posedge clk);
        #1;
        re  = r_e;
        ra  = r_a;
        we  = w_e;
        wa  = w_a;
        di  = w_d;
        pwr = $urandom;
        if (model_on) begin
            for (int k = 0; k < 2; k++) begin
                if (r_e) begin
                    exp_t e;
                    e.due = cyc + lat_k[k];
                    if (int'(r_a) >= depth_k[k])
                        e.data = 32'h0;
                    else if (w_e && (w_a == r_a) && (bypass_k[k] == 1))
                        e.data = w_d;
                    else
                        e.data = mdl[k][r_a];
                    sb[k].push_back(e);
                end
                if (w_e && (int'(w_a) < depth_k[k]))
                    mdl[k][w_a] = w_d;
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    endtask

    // Monitor: pops an expectation whenever a DUT presents read data.
    always @(negedge clk) begin
        logic [31:0] dv [2];
        logic        vv [2];
        logic        bv [2];
        dv[0] = dout_a; dv[1] = dout_b;
        vv[0] = vld_a;  vv[1] = vld_b;
        bv[0] = busy_a; bv[1] = busy_b;
        for (int k = 0; k < 2; k++) begin
            if (rst_s) begin
                sb[k].delete();
                last[k] = 32'h0;
                cmp({nm[k], "_rst_dout"}, dv[k], 32'h0);
                cmp({nm[k], "_rst_vld"}, {31'h0, vv[k]}, 32'h0);
            end else if (vv[k]) begin
                n_cmp++;
                if (sb[k].size() == 0) begin
                    n_err++;
                    $display("FAIL %s_unexpected_vld: got dout_vld=1 expected 0 (cycle %0d)", nm[k], cyc);
                end else begin
                    exp_t e;
                    e = sb[k].pop_front();
                    cmp({nm[k], "_rd_data"}, dv[k], e.data);
                    cmp({nm[k], "_rd_latency"}, 32'(cyc), 32'(e.due));
                    last[k] = e.data;
                end
            end else begin
                cmp({nm[k], "_hold"}, dv[k], last[k]);
                if ((sb[k].size() != 0) && (sb[k][0].due <= cyc)) begin
                    exp_t e;
                    e = sb[k].pop_front();
                    cmp({nm[k], "_missing_vld"}, {31'h0, vv[k]}, 32'h1);
                end
                if (model_on)
                    cmp({nm[k], "_busy_after_init"}, {31'h0, bv[k]}, 32'h0);
            end
        end
    end

    initial begin
        int busy_cnt [2];
        logic [31:0] w;

        repeat (3) idle();
        rst = 1'b0;
        // Accesses during the first sweep must be ignored.
        repeat (10) step(1'b1, 5'd0, 1'b1, 5'd0, 32'hBAD0_0001);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        busy_cnt[0] = 0;
        busy_cnt[1] = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_a) busy_cnt[0]++;
            if (busy_b) busy_cnt[1]++;
            if (i >= 2 && i <= 20)
                step(1'b1, 5'd0, 1'b1, 5'd0, 32'hBAD0_0002);
            else
                idle();
        end
        cmp("a_busy_cycles", 32'(busy_cnt[0]), 32'd32);
        cmp("b_busy_cycles", 32'(busy_cnt[1]), 32'd24);

        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++)
                mdl[k][a] = 32'h0;
        model_on = 1'b1;

        // Whole address range back to back: all zero after the sweep.
        for (int a = 0; a < 32; a++)
            step(1'b1, 5'(a), 1'b0, 5'd0, 32'h0);
        idle();

        // Basic write/read and latched output across a later write.
        step(1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        step(1'b1, 5'd5, 1'b0, 5'd0, 32'h0);
        idle();
        step(1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_0001);
        repeat (3) idle();

        // Same-address collision.
        step(1'b0, 5'd0, 1'b1, 5'd7, 32'hAAAA5555);
        step(1'b1, 5'd7, 1'b1, 5'd7, 32'h12345678);
        step(1'b1, 5'd7, 1'b0, 5'd0, 32'h0);
        repeat (3) idle();

        // Consecutive reads of preloaded words.
        for (int a = 3; a <= 5; a++)
            step(1'b0, 5'd0, 1'b1, 5'(a), 32'(a));
        for (int a = 3; a <= 5; a++)
            step(1'b1, 5'(a), 1'b0, 5'd0, 32'h0);
        repeat (4) idle();

        // Out-of-range write and read.
        step(1'b0, 5'd0, 1'b1, 5'd30, 32'h0000_00FF);
        step(1'b1, 5'd30, 1'b0, 5'd0, 32'h0);
        step(1'b1, 5'd6, 1'b0, 5'd0, 32'h0);
        repeat (3) idle();

        // Randomized traffic, biased toward collisions on a few addresses.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] r_a, w_a;
            r_a = 5'($urandom_range(0, 31));
            w_a = ($urandom_range(0, 3) == 0) ? r_a : 5'($urandom_range(0, 31));
            w = $urandom;
            step(1'($urandom_range(0, 1)), r_a, 1'($urandom_range(0, 1)), w_a, w);
        end
        repeat (5) idle();

        cmp("a_queue_drained", 32'(sb[0].size()), 32'd0);
        cmp("b_queue_drained", 32'(sb[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
